// File: rtl/clk_monitor.sv
// Lock monitor for the derived clocks CCLK, PCLK and CHROMA. All three are sampled as data in the MCK domain.
// Each channel measures its period in MCK cycles and runs an IDLE/ACQ/LOCK tracker against the current mode.
module clk_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             mck,
  input  logic             reset,
  input  logic             cclk,
  input  logic             pclk,
  input  logic             chroma,
  input  logic             fast,
  input  logic             ntsc,
  input  logic             clr_err,
  output logic             cclk_lock,
  output logic             pclk_lock,
  output logic             chroma_lock,
  output logic             all_lock,
  output logic [1:0]       cclk_phase,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} chan_state_e;

  localparam int NCH       = 3;
  localparam int CH_CCLK   = 0;
  localparam int CH_PCLK   = 1;
  localparam int CH_CHROMA = 2;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_COUNT);
  localparam logic [3:0] CNT_MAX  = 4'd15;
  localparam logic [3:0] CNT_TO   = 4'd14;

  logic [NCH-1:0] clk_in;
  logic [NCH-1:0] clk_s;
  logic [NCH-1:0] clk_p;
  logic [NCH-1:0] rise_q;
  logic           fast_r, fast_rp;
  logic           ntsc_r, ntsc_rp;

  chan_state_e    state    [NCH];
  chan_state_e    state_nx [NCH];
  logic [2:0]     good     [NCH];
  logic [2:0]     good_nx  [NCH];
  logic [3:0]     cnt      [NCH];
  logic [3:0]     cnt_nx   [NCH];
  logic [3:0]     exp_per  [NCH];

  logic [NCH-1:0] mode_chg;
  logic [NCH-1:0] good_per;
  logic [NCH-1:0] timeout;
  logic [NCH-1:0] chan_err;

  logic [1:0]       n_err;
  logic [ERR_W+1:0] err_sum;
  logic [ERR_W-1:0] err_cnt_nx;

  assign clk_in = {chroma, pclk, cclk};

  // The edge flag itself is registered so every channel decision is taken from flops only;
  // state therefore moves two MCK edges after an input edge is first sampled.
  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  // NOTE: reset here is synchronous and active-high, so it lives inside the clocked branch.
  always_ff @(posedge mck) begin
    if (reset) begin
      clk_s   <= '0;
      clk_p   <= '0;
      rise_q  <= '0;
      fast_r  <= 1'b0;
      fast_rp <= 1'b0;
      ntsc_r  <= 1'b0;
      ntsc_rp <= 1'b0;
    end else begin
      clk_s   <= clk_in;
      clk_p   <= clk_s;
      rise_q  <= clk_s & ~clk_p;
      fast_r  <= fast;
      fast_rp <= fast_r;
      ntsc_r  <= ntsc;
      ntsc_rp <= ntsc_r;
    end
  end

  assign exp_per[CH_CCLK]   = 4'd3;
  assign exp_per[CH_PCLK]   = fast_r ? 4'd2 : 4'd3;
  assign exp_per[CH_CHROMA] = ntsc_r ? 4'd5 : 4'd4;

  // A mode flip resets only the channel whose divide ratio depends on it.
  assign mode_chg = {ntsc_r ^ ntsc_rp, fast_r ^ fast_rp, 1'b0};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nx[i] = state[i];
      good_nx[i]  = good[i];
      chan_err[i] = 1'b0;
      good_per[i] = (cnt[i] == exp_per[i]);
      timeout[i]  = (cnt[i] == CNT_TO) && !rise_q[i];

      if (rise_q[i])             cnt_nx[i] = 4'd1;
      else if (cnt[i] != CNT_MAX) cnt_nx[i] = cnt[i] + 4'd1;
      else                        cnt_nx[i] = cnt[i];

      if (mode_chg[i]) begin
        state_nx[i] = IDLE;
        good_nx[i]  = 3'd0;
      end else begin
        unique case (state[i])
          IDLE: begin
            if (rise_q[i]) begin
              state_nx[i] = ACQ;
              good_nx[i]  = 3'd0;
            end
          end
          ACQ: begin
            if (rise_q[i]) begin
              if (good_per[i]) begin
                good_nx[i] = good[i] + 3'd1;
                if ((good[i] + 3'd1) == LOCK_TGT) state_nx[i] = LOCK;
              end else begin
                good_nx[i] = 3'd0;
              end
            end else if (timeout[i]) begin
              state_nx[i] = IDLE;
            end
          end
          LOCK: begin
            if (rise_q[i]) begin
              if (!good_per[i]) begin
                state_nx[i] = ACQ;
                good_nx[i]  = 3'd0;
                chan_err[i] = 1'b1;
              end
            end else if (timeout[i]) begin
              state_nx[i] = IDLE;
              chan_err[i] = 1'b1;
            end
          end
          default: begin
            state_nx[i] = IDLE;
            good_nx[i]  = 3'd0;
          end
        endcase
      end
    end
  end

  assign n_err = 2'(chan_err[0]) + 2'(chan_err[1]) + 2'(chan_err[2]);

  // Two guard bits absorb the worst case of a full counter plus three errors.
  assign err_sum    = {2'b00, err_cnt} + {{ERR_W{1'b0}}, n_err};
  assign err_cnt_nx = (|err_sum[ERR_W+1:ERR_W]) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

  always_ff @(posedge mck) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        good[i]  <= 3'd0;
        cnt[i]   <= 4'd0;
      end
      all_lock <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nx[i];
        good[i]  <= good_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      all_lock <= cclk_lock & pclk_lock & chroma_lock;
      err      <= |chan_err;
      err_cnt  <= clr_err ? '0 : err_cnt_nx;
    end
  end

  assign cclk_lock   = (state[CH_CCLK] == LOCK);
  assign pclk_lock   = (state[CH_PCLK] == LOCK);
  assign chroma_lock = (state[CH_CHROMA] == LOCK);

  assign cclk_phase = cclk_lock ? 2'(cnt[CH_CCLK] - 4'd1) : 2'd0;

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: table-driven acquisition runs plus hand-built fault,
// timeout, mode-change, saturation and mid-lock reset sequences, checked through a scoreboard queue.
module tb_clk_monitor;

  localparam int NEVER = 100000;

  logic mck = 1'b0;
  always #5 mck = ~mck;

  logic       reset, cclk, pclk, chroma, fast, ntsc, clr_err;
  logic       cclk_lock, pclk_lock, chroma_lock, all_lock, err;
  logic [1:0] cclk_phase;
  logic [7:0] err_cnt;
  logic       cclk_lock2, pclk_lock2, chroma_lock2, all_lock2, err2;
  logic [1:0] cclk_phase2;
  logic [1:0] err_cnt2;

  clk_monitor #(.LOCK_COUNT(4), .ERR_W(8)) dut (
    .mck(mck), .reset(reset), .cclk(cclk), .pclk(pclk), .chroma(chroma),
    .fast(fast), .ntsc(ntsc), .clr_err(clr_err),
    .cclk_lock(cclk_lock), .pclk_lock(pclk_lock), .chroma_lock(chroma_lock),
    .all_lock(all_lock), .cclk_phase(cclk_phase), .err(err), .err_cnt(err_cnt)
  );

  clk_monitor #(.LOCK_COUNT(4), .ERR_W(2)) dut2 (
    .mck(mck), .reset(reset), .cclk(cclk), .pclk(pclk), .chroma(chroma),
    .fast(fast), .ntsc(ntsc), .clr_err(clr_err),
    .cclk_lock(cclk_lock2), .pclk_lock(pclk_lock2), .chroma_lock(chroma_lock2),
    .all_lock(all_lock2), .cclk_phase(cclk_phase2), .err(err2), .err_cnt(err_cnt2)
  );

  typedef enum int {S_CL, S_PL, S_HL, S_AL, S_PH, S_ERR, S_CNT, S_CNT2} sig_e;
  typedef struct { int at; sig_e sig; int val; } exp_t;
  typedef struct {
    logic fast, ntsc;
    int   per_c, per_p, per_h;
    int   lock_c, lock_p, lock_h;
  } row_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;
  int   per [3];
  int   nxt [3];
  int   cnt_m, cnt2_m;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic string sig_name(input sig_e s);
    case (s)
      S_CL:    return "cclk_lock";
      S_PL:    return "pclk_lock";
      S_HL:    return "chroma_lock";
      S_AL:    return "all_lock";
      S_PH:    return "cclk_phase";
      S_ERR:   return "err";
      S_CNT:   return "err_cnt";
      default: return "err_cnt_w2";
    endcase
  endfunction

  function automatic int actual(input sig_e s);
    case (s)
      S_CL:    return int'(cclk_lock);
      S_PL:    return int'(pclk_lock);
      S_HL:    return int'(chroma_lock);
      S_AL:    return int'(all_lock);
      S_PH:    return int'(cclk_phase);
      S_ERR:   return int'(err);
      S_CNT:   return int'(err_cnt);
      default: return int'(err_cnt2);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp_v);
    end
  endtask

  task automatic push(input sig_e s, input int v);
    sb.push_back('{at: n, sig: s, val: v});
  endtask

  task automatic push_locks(input int cl, input int pl, input int hl, input int al);
    push(S_CL, cl); push(S_PL, pl); push(S_HL, hl); push(S_AL, al);
  endtask

  task automatic push_zero_all();
    push_locks(0, 0, 0, 0);
    push(S_PH, 0); push(S_ERR, 0); push(S_CNT, 0); push(S_CNT2, 0);
  endtask

  // Drive one MCK edge worth of clock pulses, then retire the expectations queued for that edge.
  task automatic step();
    logic [2:0] b;
    @(negedge mck);
    for (int c = 0; c < 3; c++) begin
      b[c] = (n == nxt[c]);
      if (b[c]) nxt[c] = n + per[c];
    end
    cclk   = b[0];
    pclk   = b[1];
    chroma = b[2];
    @(posedge mck);
    #1;
    while (sb.size() > 0 && sb[0].at <= n) begin
      exp_t e;
      e = sb.pop_front();
      check(sig_name(e.sig), actual(e.sig), e.val);
    end
    n++;
  endtask

  task automatic run_until(input int stop);
    while (n < stop) step();
  endtask

  task automatic start_run(input logic f, input logic t, input int pc, input int pp, input int ph);
    fast    = f;
    ntsc    = t;
    clr_err = 1'b0;
    reset   = 1'b1;
    per     = '{pc, pp, ph};
    nxt     = '{0, 0, 0};
    n       = -3;
    repeat (2) step();
    push_zero_all();
    step();
    reset  = 1'b0;
    cnt_m  = 0;
    cnt2_m = 0;
  endtask

  // One channel drops out of LOCK for [lo, hi); ALL_LOCK follows one edge later.
  task automatic drop_window(input int ch, input int lo, input int hi, input int err_at, input int stop);
    int lk, al;
    while (n < stop) begin
      lk = int'(!(n >= lo && n < hi));
      al = int'(!(n >= lo + 1 && n < hi + 1));
      push_locks((ch == 0) ? lk : 1, (ch == 1) ? lk : 1, (ch == 2) ? lk : 1, al);
      push(S_ERR, int'(n == err_at));
      push(S_CNT, int'(err_at >= 0 && n >= err_at));
      step();
    end
  endtask

  task automatic wait_all_lock();
    int budget;
    budget = 100;
    while (all_lock !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    check("all_lock_wait", int'(all_lock), 1);
  endtask

  // Realign all three clocks on one late edge: every channel sees a long, bad period together.
  task automatic fault_all(input logic clr);
    int r_edge;
    wait_all_lock();
    r_edge = imax(imax(nxt[0], nxt[1]), nxt[2]) + 1;
    for (int c = 0; c < 3; c++) nxt[c] = r_edge;
    if (clr) clr_err = 1'b1;
    cnt_m  = clr ? 0 : sat(cnt_m + 3, 255);
    cnt2_m = clr ? 0 : sat(cnt2_m + 3, 3);
    while (n < r_edge + 2) begin
      if (n == r_edge + 1) begin
        push_locks(1, 1, 1, 1);
        push(S_ERR, 0);
        if (clr) begin
          push(S_CNT, 0);
          push(S_CNT2, 0);
        end
      end
      step();
    end
    push_locks(0, 0, 0, 1);
    push(S_ERR, 1);
    push(S_CNT, cnt_m);
    push(S_CNT2, cnt2_m);
    step();
    clr_err = 1'b0;
    push(S_AL, 0);
    push(S_ERR, 0);
    push(S_CNT, cnt_m);
    push(S_CNT2, cnt2_m);
    step();
  endtask

  task automatic reset_mid();
    int lc [3];
    int al_e;
    wait_all_lock();
    reset = 1'b1;
    push_zero_all();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) lc[c] = nxt[c] + 2 + 4 * per[c];
    al_e = imax(imax(lc[0], lc[1]), lc[2]) + 1;
    while (n <= al_e) begin
      push_locks(int'(n >= lc[0]), int'(n >= lc[1]), int'(n >= lc[2]), int'(n >= al_e));
      push(S_ERR, 0);
      push(S_CNT, 0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows [4];
    int   al_e, cl;

    reset = 1'b1; cclk = 1'b0; pclk = 1'b0; chroma = 1'b0;
    fast = 1'b0; ntsc = 1'b0; clr_err = 1'b0;
    n = -10;

    // {fast, ntsc, cclk/pclk/chroma period, expected lock edges}
    rows[0] = '{1'b0, 1'b0, 3, 3, 4, 14, 14, 18};
    rows[1] = '{1'b1, 1'b1, 3, 2, 5, 14, 10, 22};
    rows[2] = '{1'b1, 1'b1, 3, 3, 4, 14, NEVER, NEVER};
    rows[3] = '{1'b0, 1'b1, 4, 3, 5, NEVER, 14, 22};

    for (int r = 0; r < 4; r++) begin
      start_run(rows[r].fast, rows[r].ntsc, rows[r].per_c, rows[r].per_p, rows[r].per_h);
      al_e = imax(imax(rows[r].lock_c, rows[r].lock_p), rows[r].lock_h);
      al_e = (al_e >= NEVER) ? NEVER : al_e + 1;
      for (int k = 0; k < 30; k++) begin
        cl = int'(n >= rows[r].lock_c);
        push_locks(cl, int'(n >= rows[r].lock_p), int'(n >= rows[r].lock_h), int'(n >= al_e));
        push(S_PH, (cl != 0) ? ((n - 2) % 3) : 0);
        push(S_ERR, 0);
        push(S_CNT, 0);
        step();
      end
    end

    // CCLK period stretched to 4 once while locked.
    start_run(1'b0, 1'b0, 3, 3, 4);
    run_until(31);
    nxt[0] = 34;
    drop_window(0, 36, 48, 36, 56);

    // CHROMA silent long enough to time out, then restarted.
    start_run(1'b0, 1'b0, 3, 3, 4);
    run_until(29);
    nxt[2] = 48;
    drop_window(2, 44, 66, 44, 72);

    // FAST 0->1 with PCLK switching to divide-by-2; the in-flight rise is discarded.
    start_run(1'b0, 1'b0, 3, 3, 4);
    run_until(31);
    fast   = 1'b1;
    per[1] = 2;
    nxt[1] = 32;
    drop_window(1, 32, 42, -1, 52);

    // Triple faults: saturation on the 2-bit counter, clear racing a fault, then mid-lock reset.
    start_run(1'b0, 1'b0, 3, 3, 4);
    fault_all(1'b0);
    fault_all(1'b0);
    fault_all(1'b1);
    fault_all(1'b0);
    reset_mid();

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
